// File: rtl/conv_weight_loader.sv
// Parameter-load sequencer for one conv layer: streams 16-bit words onto the
// shared weight write bus at consecutive addresses and gates layer_en on completion.
module conv_weight_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic [15:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [15:0]            weight_wr_data,
    output logic [ADDR_WIDTH-1:0]  weight_wr_addr,
    output logic                   weight_wr_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   layer_en
);

    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST =
        STALL_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] idx_q;
    logic [STALL_W-1:0]     stall_q;
    logic                   s_ready_q;
    logic                   wr_en_q;
    logic [15:0]            wr_data_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic                   done_q;
    logic                   err_q;
    logic                   layer_en_q;

    logic start_load;
    logic accept;
    logic last_beat;
    logic timeout_hit;

    // s_ready_q is only ever high while in LOAD, so it alone qualifies a beat.
    assign accept      = s_valid && s_ready_q;
    assign last_beat   = (idx_q == count_q - COUNT_WIDTH'(1));
    assign timeout_hit = TIMEOUT_EN && (stall_q == STALL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    start_load = 1'b1;
                    state_d    = (cfg_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_beat) begin
                    state_d = DONE;
                end else if (!accept && timeout_hit) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            stall_q    <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            layer_en_q <= 1'b0;
        end else begin
            // Flags follow the next state so they line up with the state they describe.
            s_ready_q <= (state_d == LOAD);
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == ERR);

            if (state_d == DONE) begin
                layer_en_q <= 1'b1;
            end else if (start_load || abort) begin
                layer_en_q <= 1'b0;
            end

            if (start_load) begin
                base_q  <= cfg_base_addr;
                count_q <= cfg_count;
                idx_q   <= '0;
            end else if (accept) begin
                idx_q <= idx_q + COUNT_WIDTH'(1);
            end

            if (start_load || accept) begin
                stall_q <= '0;
            end else if (state_q == LOAD && TIMEOUT_EN) begin
                stall_q <= stall_q + STALL_W'(1);
            end

            // Independent of abort so a beat accepted alongside abort still lands.
            if (accept) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= s_data;
                wr_addr_q <= base_q + ADDR_WIDTH'(idx_q);
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign s_ready        = s_ready_q;
    assign weight_wr_en   = wr_en_q;
    assign weight_wr_data = wr_data_q;
    assign weight_wr_addr = wr_addr_q;
    assign busy           = (state_q == LOAD);
    assign done           = done_q;
    assign err            = err_q;
    assign layer_en       = layer_en_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: cycle model of the load protocol checked every
// cycle, plus literal expectations on the write log of each directed scenario.
module tb_conv_weight_loader;

    localparam int TO = 8;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_DONE = 2;
    localparam int P_ERR  = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_base_addr;
    logic [23:0] cfg_count;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        busy;
    logic        done;
    logic        err;
    logic        layer_en;

    conv_weight_loader #(
        .ADDR_WIDTH     (32),
        .COUNT_WIDTH    (24),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_count      (cfg_count),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .weight_wr_data (weight_wr_data),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_en   (weight_wr_en),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .layer_en       (layer_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one protocol step per clock edge.
    bit          m_init = 0;
    int          m_phase;
    logic [31:0] m_base;
    int unsigned m_count, m_idx, m_stall;
    bit          m_acc;
    bit          m_ready, m_wen, m_done, m_err, m_layer;
    logic [15:0] m_wdata;
    logic [31:0] m_waddr;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1;
            m_phase = P_IDLE;
            m_base  = 0; m_count = 0; m_idx = 0; m_stall = 0;
            m_ready = 0; m_wen = 0; m_done = 0; m_err = 0; m_layer = 0;
            m_wdata = 0; m_waddr = 0;
        end else if (m_init) begin
            m_acc = (m_phase == P_LOAD) && s_valid;
            m_wen = m_acc;
            if (m_acc) begin
                m_wdata = s_data;
                m_waddr = m_base + m_idx;
            end
            case (m_phase)
                P_IDLE, P_ERR: begin
                    if (abort) begin
                        m_layer = 0;
                        m_phase = P_IDLE;
                    end else if (start) begin
                        m_base  = cfg_base_addr;
                        m_count = cfg_count;
                        m_idx   = 0;
                        m_stall = 0;
                        m_layer = 0;
                        m_phase = (cfg_count == 0) ? P_DONE : P_LOAD;
                    end
                end
                P_LOAD: begin
                    if (abort) begin
                        m_layer = 0;
                        m_phase = P_IDLE;
                    end else if (m_acc) begin
                        m_idx++;
                        m_stall = 0;
                        if (m_idx == m_count) m_phase = P_DONE;
                    end else begin
                        m_stall++;
                        if (m_stall == TO) m_phase = P_ERR;
                    end
                end
                default: begin
                    if (abort) m_layer = 0;
                    m_phase = P_IDLE;
                end
            endcase
            m_done = (m_phase == P_DONE);
            if (m_done) m_layer = 1;
            m_ready = (m_phase == P_LOAD);
            m_err   = (m_phase == P_ERR);
        end
    end

    logic [31:0] log_addr[$];
    logic [15:0] log_data[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("s_ready",  s_ready,        m_ready);
            chk("wr_en",    weight_wr_en,   m_wen);
            chk("wr_data",  weight_wr_data, m_wdata);
            chk("wr_addr",  weight_wr_addr, m_waddr);
            chk("busy",     busy,           m_phase == P_LOAD);
            chk("done",     done,           m_done);
            chk("err",      err,            m_err);
            chk("layer_en", layer_en,       m_layer);
            if (weight_wr_en === 1'b1) begin
                log_addr.push_back(weight_wr_addr);
                log_data.push_back(weight_wr_data);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [23:0] c);
        cfg_base_addr = b;
        cfg_count     = c;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx,
                           input logic [31:0] a, input logic [15:0] d);
        if (idx < log_addr.size()) begin
            chk({name, "_addr"}, log_addr[idx], a);
            chk({name, "_data"}, log_data[idx], d);
        end else begin
            chk({name, "_missing"}, log_addr.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[6];
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_base_addr = '0; cfg_count = '0; s_data = '0; s_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset_ready", s_ready, 0);
        chk("reset_en",    weight_wr_en, 0);
        chk("reset_addr",  weight_wr_addr, 0);
        chk("reset_layer", layer_en, 0);
        idle(2);

        // basic back-to-back load
        clear_logs();
        do_start(32'd17176, 24'd4);
        beat(16'h0011); beat(16'h0022); beat(16'h0033); beat(16'h0044);
        idle(3);
        chk("basic_nwr", log_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_log("basic", i, 32'd17176 + 32'(i), 16'(16'h0011 * (i + 1)));
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_layer_en", layer_en, 1);

        // backpressure gaps
        clear_logs();
        pat = '{1, 0, 0, 1, 0, 1};
        do_start(32'd500, 24'd3);
        for (int i = 0; i < 6; i++) begin
            s_valid = pat[i];
            s_data  = 16'hA000 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        idle(3);
        chk("gap_nwr", log_addr.size(), 3);
        chk_log("gap0", 0, 32'd500, 16'hA000);
        chk_log("gap1", 1, 32'd501, 16'hA003);
        chk_log("gap2", 2, 32'd502, 16'hA005);
        chk("gap_done_cnt", done_cnt, 1);

        // zero count
        clear_logs();
        do_start(32'd77, 24'd0);
        chk("zero_done", done, 1);
        idle(2);
        chk("zero_nwr", log_addr.size(), 0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_layer_en", layer_en, 1);

        // address wrap
        clear_logs();
        do_start(32'hFFFF_FFFF, 24'd2);
        beat(16'hBEEF); beat(16'hCAFE);
        idle(3);
        chk_log("wrap0", 0, 32'hFFFF_FFFF, 16'hBEEF);
        chk_log("wrap1", 1, 32'h0000_0000, 16'hCAFE);

        // timeout then recovery
        clear_logs();
        do_start(32'd1000, 24'd5);
        beat(16'h5001); beat(16'h5002);
        idle(TO - 1);
        chk("to_err_early", err, 0);
        tick();
        chk("to_err", err, 1);
        chk("to_ready", s_ready, 0);
        s_valid = 1'b1; s_data = 16'h5EEE;
        idle(4);
        s_valid = 1'b0;
        idle(1);
        chk("to_nwr", log_addr.size(), 2);
        clear_logs();
        do_start(32'd1200, 24'd5);
        chk("to_err_clr", err, 0);
        for (int i = 0; i < 5; i++) beat(16'h6000 + 16'(i));
        idle(3);
        chk("to_re_nwr", log_addr.size(), 5);
        chk_log("to_re4", 4, 32'd1204, 16'h6004);
        chk("to_re_done_cnt", done_cnt, 1);

        // abort with a beat accepted in the same cycle
        clear_logs();
        do_start(32'd2000, 24'd6);
        beat(16'h0A01);
        s_valid = 1'b1; s_data = 16'h0A02; abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_busy", busy, 0);
        idle(3);
        chk("abort_nwr", log_addr.size(), 2);
        chk_log("abort1", 1, 32'd2001, 16'h0A02);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_layer_en", layer_en, 0);

        // reset mid-load
        clear_logs();
        do_start(32'd3000, 24'd4);
        beat(16'h3001);
        s_valid = 1'b1; s_data = 16'h3002; rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        chk("mrst_en",    weight_wr_en, 0);
        chk("mrst_ready", s_ready, 0);
        chk("mrst_busy",  busy, 0);
        chk("mrst_addr",  weight_wr_addr, 0);
        chk("mrst_data",  weight_wr_data, 0);
        clear_logs();
        do_start(32'd4000, 24'd2);
        beat(16'h4001); beat(16'h4002);
        idle(3);
        chk_log("mrst0", 0, 32'd4000, 16'h4001);
        chk_log("mrst1", 1, 32'd4001, 16'h4002);

        // start ignored while busy
        clear_logs();
        do_start(32'd5000, 24'd3);
        beat(16'h0001);
        cfg_base_addr = 32'd100; cfg_count = 24'd9; start = 1'b1;
        s_valid = 1'b1; s_data = 16'h0002;
        tick();
        start = 1'b0; s_valid = 1'b0;
        beat(16'h0003);
        idle(3);
        chk("ign_nwr", log_addr.size(), 3);
        chk_log("ign2", 2, 32'd5002, 16'h0003);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
